// File: rtl/note_key_tx.sv
// note_key_tx: samples 12 note pads, encodes the lowest pressed pad as an
// ASCII key code and sends each new code as a UART 8N1 frame.
// Ports:
//   clk     - main clock, rising edge
//   rstb    - asynchronous active-low reset
//   inNote  - note pads, bit 0 = C .. bit 11 = B, 1 = pressed
//   outTx   - UART serial line, idle high
//   outBusy - high while a frame is in progress
//   outCode - code of the most recently launched frame
module note_key_tx #(
   parameter int C_CLK_FRQ   = 100_000_000,
   parameter int C_UART_RATE = 115_200
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic [11:0] inNote,
   output logic        outTx,
   output logic        outBusy,
   output logic [7:0]  outCode
);

   localparam int C_BAUD_DIV = C_CLK_FRQ / C_UART_RATE;
   localparam int CW = (C_BAUD_DIV > 1) ? $clog2(C_BAUD_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(C_BAUD_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } stateT;

   stateT          state, stateNext;
   logic [11:0]    noteMeta, noteSync;
   logic [7:0]     code, codeNext;
   logic [7:0]     lastCode, lastNext;
   logic [7:0]     codeOutNext;
   logic [7:0]     shReg, shNext;
   logic [CW-1:0]  cnt, cntNext;
   logic [2:0]     bitIdx, bitNext;
   logic           txNext, busyNext;
   logic           wrap;

   function automatic logic [7:0] keyOf(input logic [3:0] idx);
      logic [7:0] k;
      case (idx)
         4'd0:    k = 8'h7A;
         4'd1:    k = 8'h73;
         4'd2:    k = 8'h78;
         4'd3:    k = 8'h64;
         4'd4:    k = 8'h63;
         4'd5:    k = 8'h76;
         4'd6:    k = 8'h67;
         4'd7:    k = 8'h62;
         4'd8:    k = 8'h68;
         4'd9:    k = 8'h6E;
         4'd10:   k = 8'h6A;
         4'd11:   k = 8'h6D;
         default: k = 8'h00;
      endcase
      return k;
   endfunction

   // Scan from the top so the lowest pressed pad overwrites last.
   always_comb begin
      codeNext = 8'h00;
      for (int i = 11; i >= 0; i--) begin
         if (noteSync[i]) codeNext = keyOf(4'(i));
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         noteMeta <= '0;
         noteSync <= '0;
         code     <= 8'h00;
      end else begin
         noteMeta <= inNote;
         noteSync <= noteMeta;
         code     <= codeNext;
      end
   end

   assign wrap = (cnt == CNT_LAST);

   always_comb begin
      stateNext   = state;
      cntNext     = cnt;
      bitNext     = bitIdx;
      shNext      = shReg;
      txNext      = outTx;
      busyNext    = outBusy;
      lastNext    = lastCode;
      codeOutNext = outCode;
      unique case (state)
         IDLE: begin
            txNext = 1'b1;
            // Codes that changed and changed back during a frame
            // never reach this compare, so they are dropped.
            if (code != lastCode) begin
               lastNext    = code;
               codeOutNext = code;
               shNext      = code;
               cntNext     = '0;
               bitNext     = 3'd0;
               txNext      = 1'b0;
               busyNext    = 1'b1;
               stateNext   = START;
            end
         end
         START: begin
            if (wrap) begin
               cntNext   = '0;
               txNext    = shReg[0];
               shNext    = shReg >> 1;
               stateNext = DATA;
            end else begin
               cntNext = cnt + 1'b1;
            end
         end
         DATA: begin
            if (wrap) begin
               cntNext = '0;
               if (bitIdx == 3'd7) begin
                  txNext    = 1'b1;
                  stateNext = STOP;
               end else begin
                  bitNext = bitIdx + 3'd1;
                  txNext  = shReg[0];
                  shNext  = shReg >> 1;
               end
            end else begin
               cntNext = cnt + 1'b1;
            end
         end
         STOP: begin
            if (wrap) begin
               cntNext   = '0;
               busyNext  = 1'b0;
               stateNext = IDLE;
            end else begin
               cntNext = cnt + 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state    <= IDLE;
         cnt      <= '0;
         bitIdx   <= 3'd0;
         shReg    <= 8'h00;
         outTx    <= 1'b1;
         outBusy  <= 1'b0;
         lastCode <= 8'h00;
         outCode  <= 8'h00;
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         bitIdx   <= bitNext;
         shReg    <= shNext;
         outTx    <= txNext;
         outBusy  <= busyNext;
         lastCode <= lastNext;
         outCode  <= codeOutNext;
      end
   end

endmodule

// File: tb/tb_note_key_tx.sv
// tb_note_key_tx: directed and randomized bench for note_key_tx with a
// UART receiver monitor and a key-code reference model.
`timescale 1ns/1ps
module tb_note_key_tx;

   localparam int DIV = 10;
   localparam int FRAME = 10 * DIV;

   logic        clk;
   logic        rstb;
   logic [11:0] inNote;
   logic        outTx;
   logic        outBusy;
   logic [7:0]  outCode;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   note_key_tx #(
      .C_CLK_FRQ(100_000_000),
      .C_UART_RATE(10_000_000)
   ) dut (
      .clk(clk),
      .rstb(rstb),
      .inNote(inNote),
      .outTx(outTx),
      .outBusy(outBusy),
      .outCode(outCode)
   );

   initial begin
      clk = 1'b0;
      forever begin
         #(5.0 + (real'($urandom_range(0, 100)) - 50.0) / 1000.0);
         clk = ~clk;
      end
   end

   always @(posedge clk) cyc++;

   string keys = "zsxdcvgbhnjm";

   function automatic logic [7:0] model(input logic [11:0] p);
      for (int i = 0; i < 12; i++) begin
         if (p[i]) return keys[i];
      end
      return 8'h00;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [7:0] rxQ[$];
   int         startQ[$];
   int         busyQ[$];
   int         fallCnt = 0;
   logic       rxActive = 1'b0;
   logic       prevTx = 1'b1;
   int         rxStart = 0;
   logic [7:0] rxByte;
   int         busyLen = 0;

   always @(negedge clk) begin
      if (!rstb) begin
         rxActive = 1'b0;
         prevTx = 1'b1;
         busyLen = 0;
      end else begin
         if (!rxActive && prevTx && !outTx) begin
            rxActive = 1'b1;
            rxStart = cyc;
            fallCnt++;
            startQ.push_back(cyc);
         end
         if (rxActive) begin
            int off;
            int idx;
            off = cyc - rxStart;
            if (off % DIV == DIV / 2) begin
               idx = off / DIV;
               if (idx == 0) check("start_bit", 32'(outTx), 0);
               else if (idx <= 8) rxByte[idx-1] = outTx;
               else begin
                  check("stop_bit", 32'(outTx), 1);
                  rxQ.push_back(rxByte);
                  rxActive = 1'b0;
               end
            end
         end
         prevTx = outTx;
         if (outBusy) busyLen++;
         else if (busyLen > 0) begin
            busyQ.push_back(busyLen);
            busyLen = 0;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitFall(input string tag, input int budget);
      int f0;
      logic seen;
      f0 = fallCnt;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (fallCnt > f0) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_fall"}, 32'(seen), 1);
   endtask

   task automatic checkFrame(input string tag, input logic [7:0] exp);
      check({tag, "_have"}, 32'(rxQ.size() > 0), 1);
      if (rxQ.size() > 0) check(tag, 32'(rxQ.pop_front()), 32'(exp));
      if (startQ.size() > 0) void'(startQ.pop_front());
      check({tag, "_busyhave"}, 32'(busyQ.size() > 0), 1);
      if (busyQ.size() > 0)
         check({tag, "_busylen"}, busyQ.pop_front(), FRAME);
   endtask

   task automatic checkNone(input string tag);
      check(tag, rxQ.size(), 0);
   endtask

   logic [11:0] pat;
   logic [7:0]  expc;
   logic [7:0]  lastModel;
   int          chgCyc;
   int          c0;
   int          lowIdx;
   logic [11:0] hi;

   initial begin
      rstb = 1'b0;
      inNote = 12'h000;
      #100;
      check("rst_tx", 32'(outTx), 1);
      check("rst_busy", 32'(outBusy), 0);
      check("rst_code", 32'(outCode), 0);
      #100;
      @(negedge clk);
      rstb = 1'b1;
      cycles(200);
      check("idle_nofall", fallCnt, 0);
      check("idle_tx", 32'(outTx), 1);
      check("idle_busy", 32'(outBusy), 0);
      check("idle_code", 32'(outCode), 0);

      @(posedge clk);
      #1;
      inNote = 12'h001;
      chgCyc = cyc;
      waitFall("c_lat", 20);
      if (startQ.size() > 0)
         check("c_latency", startQ[0] - chgCyc, 4);
      cycles(FRAME + 10);
      checkFrame("c_frame", 8'h7A);
      check("c_code", 32'(outCode), 32'h7A);
      cycles(500);
      checkNone("c_hold");

      inNote = 12'h801;
      cycles(130);
      checkNone("cb_none");
      inNote = 12'h800;
      cycles(130);
      checkFrame("b_frame", 8'h6D);
      inNote = 12'h000;
      cycles(130);
      checkFrame("rel_frame", 8'h00);

      inNote = 12'h002;
      waitFall("s4", 20);
      cycles(30);
      inNote = 12'h004;
      cycles(20);
      inNote = 12'h008;
      cycles(250);
      check("s4_count", rxQ.size(), 2);
      if (startQ.size() >= 2)
         check("s4_gap", 32'(startQ[1] - startQ[0] >= FRAME + 1), 1);
      checkFrame("s4_first", 8'h73);
      checkFrame("s4_second", 8'h64);
      checkNone("s4_nomore");
      inNote = 12'h000;
      cycles(130);
      checkFrame("s4_rel", 8'h00);

      inNote = 12'h002;
      waitFall("s5", 20);
      cycles(20);
      inNote = 12'h000;
      cycles(20);
      inNote = 12'h002;
      cycles(250);
      checkFrame("s5_frame", 8'h73);
      checkNone("s5_nomore");
      inNote = 12'h000;
      cycles(130);
      checkFrame("s5_rel", 8'h00);

      inNote = 12'h010;
      waitFall("s6", 20);
      while (cyc < startQ[0] + 40) @(negedge clk);
      c0 = cyc;
      #1;
      rstb = 1'b0;
      #1;
      check("s6_tx_async", 32'(outTx), 1);
      check("s6_busy_async", 32'(outBusy), 0);
      check("s6_code_async", 32'(outCode), 0);
      check("s6_noedge", cyc, c0);
      rxQ.delete();
      startQ.delete();
      busyQ.delete();
      cycles(20);
      rstb = 1'b1;
      cycles(150);
      checkFrame("s6_refresh", 8'h63);
      checkNone("s6_nomore");
      inNote = 12'h000;
      cycles(130);
      checkFrame("s6_rel", 8'h00);

      lastModel = 8'h00;
      pat = 12'h000;
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 3))
            0: pat = 12'h000;
            1: pat = 12'($urandom);
            2: begin
               if (pat == 12'h000) pat = 12'($urandom);
               else begin
                  lowIdx = 0;
                  while (!pat[lowIdx]) lowIdx++;
                  hi = 12'($urandom) & ~((12'h1 << (lowIdx + 1)) - 12'h1);
                  pat = pat | hi;
               end
            end
            default: pat = 12'h1 << $urandom_range(0, 11);
         endcase
         inNote = pat;
         expc = model(pat);
         cycles(130);
         if (expc != lastModel) begin
            checkFrame("rnd_frame", expc);
            lastModel = expc;
         end else begin
            checkNone("rnd_hold");
         end
         check("rnd_code", 32'(outCode), 32'(lastModel));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
